// File: rtl/pc_redirect.sv
// Fetch PC sequencer: sequential fetch, PC-relative and register-indirect redirects,
// with one squash cycle after every redirect and a hazard stall that freezes everything.
//
// state  | meaning
// BOOT   | out of reset, pc = RESET_PC, fetch not yet valid
// RUN    | normal fetch, ID-stage branch decisions are honoured
// SQUASH | slot after a redirect, ID holds a squashed instruction
module pc_redirect #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        BrTaken,
    input  logic        UncondBr,
    input  logic        pc_rd,
    input  logic [25:0] br_addr26,
    input  logic [18:0] cond_addr19,
    input  logic [63:0] regVal_in,
    input  logic [63:0] id_pc,
    input  logic        id_valid,
    input  logic        stall,
    output logic [63:0] pc,
    output logic        fetch_valid,
    output logic        if_id_flush,
    output logic        align_err,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic        r_fetch_valid;
    logic        r_align_err;
    logic [15:0] r_redirect_cnt;

    logic        w_redirect;
    logic [63:0] w_offset;
    logic [63:0] w_target;

    assign w_redirect = (r_state == RUN) && id_valid && !stall && (pc_rd || BrTaken);

    // Immediates are word offsets: sign-extend, then scale by 4.
    assign w_offset = UncondBr ? {{36{br_addr26[25]}}, br_addr26, 2'b00}
                               : {{43{cond_addr19[18]}}, cond_addr19, 2'b00};

    assign w_target = pc_rd ? {regVal_in[63:2], 2'b00} : (id_pc + w_offset);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= BOOT;
            r_pc           <= RESET_PC;
            r_fetch_valid  <= 1'b0;
            r_align_err    <= 1'b0;
            r_redirect_cnt <= 16'h0;
        end else if (!stall) begin
            case (r_state)
                BOOT: begin
                    r_state       <= RUN;
                    r_fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (w_redirect) begin
                        r_pc           <= w_target;
                        r_state        <= SQUASH;
                        r_redirect_cnt <= r_redirect_cnt + 16'd1;
                        if (pc_rd && (regVal_in[1:0] != 2'b00))
                            r_align_err <= 1'b1;
                    end else begin
                        r_pc <= r_pc + 64'd4;
                    end
                end
                SQUASH: begin
                    r_pc    <= r_pc + 64'd4;
                    r_state <= RUN;
                end
                default: begin
                    r_state       <= BOOT;
                    r_pc          <= RESET_PC;
                    r_fetch_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = r_pc;
    assign fetch_valid  = r_fetch_valid;
    assign if_id_flush  = w_redirect;
    assign align_err    = r_align_err;
    assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed bench for pc_redirect: hand-computed PC sequences, redirects, stalls,
// wrap-around and asynchronous reset.
module tb_pc_redirect;

    logic        clk;
    logic        reset_n;
    logic        BrTaken;
    logic        UncondBr;
    logic        pc_rd;
    logic [25:0] br_addr26;
    logic [18:0] cond_addr19;
    logic [63:0] regVal_in;
    logic [63:0] id_pc;
    logic        id_valid;
    logic        stall;
    logic [63:0] pc;
    logic        fetch_valid;
    logic        if_id_flush;
    logic        align_err;
    logic [15:0] redirect_cnt;

    int total = 0;
    int bad   = 0;

    pc_redirect #(.RESET_PC(64'h0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .BrTaken      (BrTaken),
        .UncondBr     (UncondBr),
        .pc_rd        (pc_rd),
        .br_addr26    (br_addr26),
        .cond_addr19  (cond_addr19),
        .regVal_in    (regVal_in),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .stall        (stall),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .if_id_flush  (if_id_flush),
        .align_err    (align_err),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_br();
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        pc_rd       = 1'b0;
        br_addr26   = '0;
        cond_addr19 = '0;
        regVal_in   = '0;
        id_pc       = '0;
        id_valid    = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        clear_br();

        // reset values and BOOT
        #12;
        check("rst_pc", pc, 64'h0);
        check("rst_fv", {63'h0, fetch_valid}, 64'h0);
        check("rst_align", {63'h0, align_err}, 64'h0);
        check("rst_cnt", {48'h0, redirect_cnt}, 64'h0);
        check("rst_flush", {63'h0, if_id_flush}, 64'h0);
        reset_n = 1'b1;
        #1;
        check("boot_pc", pc, 64'h0);
        check("boot_fv", {63'h0, fetch_valid}, 64'h0);

        // sequential fetch
        step();
        check("seq0_pc", pc, 64'h0);
        check("seq0_fv", {63'h0, fetch_valid}, 64'h1);
        step();
        check("seq1_pc", pc, 64'h4);
        step();
        check("seq2_pc", pc, 64'h8);

        // unconditional branch, offset -2 words from 0x100
        id_valid  = 1'b1;
        BrTaken   = 1'b1;
        UncondBr  = 1'b1;
        br_addr26 = 26'h3FFFFFE;
        id_pc     = 64'h100;
        #1;
        check("b_flush", {63'h0, if_id_flush}, 64'h1);
        step();
        check("b_pc", pc, 64'hF8);
        check("b_cnt", {48'h0, redirect_cnt}, 64'h1);
        // branch inputs still asserted in SQUASH must be ignored
        check("sq_flush", {63'h0, if_id_flush}, 64'h0);
        step();
        check("sq_pc", pc, 64'hFC);
        check("sq_cnt", {48'h0, redirect_cnt}, 64'h1);
        clear_br();
        step();
        check("run_pc", pc, 64'h100);

        // BR with misaligned register, pc_rd wins over BrTaken
        id_valid  = 1'b1;
        pc_rd     = 1'b1;
        BrTaken   = 1'b1;
        UncondBr  = 1'b1;
        br_addr26 = 26'h10;
        id_pc     = 64'h500;
        regVal_in = 64'h2003;
        #1;
        check("br_flush", {63'h0, if_id_flush}, 64'h1);
        step();
        check("br_pc", pc, 64'h2000);
        check("br_align", {63'h0, align_err}, 64'h1);
        check("br_cnt", {48'h0, redirect_cnt}, 64'h2);
        clear_br();
        step();
        check("br_sq_pc", pc, 64'h2004);
        step();
        check("br_run_pc", pc, 64'h2008);
        check("align_sticky", {63'h0, align_err}, 64'h1);

        // stalled conditional branch
        stall       = 1'b1;
        id_valid    = 1'b1;
        BrTaken     = 1'b1;
        UncondBr    = 1'b0;
        cond_addr19 = 19'd4;
        id_pc       = 64'h40;
        #1;
        check("stall_flush", {63'h0, if_id_flush}, 64'h0);
        step();
        check("stall_pc0", pc, 64'h2008);
        step();
        check("stall_pc1", pc, 64'h2008);
        check("stall_cnt", {48'h0, redirect_cnt}, 64'h2);
        stall = 1'b0;
        #1;
        check("unstall_flush", {63'h0, if_id_flush}, 64'h1);
        step();
        check("unstall_pc", pc, 64'h50);
        check("unstall_cnt", {48'h0, redirect_cnt}, 64'h3);
        clear_br();
        // stall while in SQUASH holds pc
        stall = 1'b1;
        step();
        check("sq_stall_pc", pc, 64'h50);
        stall = 1'b0;
        step();
        check("sq_resume_pc", pc, 64'h54);

        // pc wrap at 2^64
        id_valid  = 1'b1;
        pc_rd     = 1'b1;
        regVal_in = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        check("wrap_pre_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_cnt4", {48'h0, redirect_cnt}, 64'h4);
        clear_br();
        step();
        check("wrap_pc", pc, 64'h0);
        check("align_still", {63'h0, align_err}, 64'h1);

        // redirect counter wrap
        force dut.r_redirect_cnt = 16'hFFFF;
        #1;
        release dut.r_redirect_cnt;
        #1;
        id_valid    = 1'b1;
        BrTaken     = 1'b1;
        UncondBr    = 1'b0;
        cond_addr19 = 19'd0;
        id_pc       = 64'h300;
        step();
        check("cnt_wrap", {48'h0, redirect_cnt}, 64'h0);
        check("cnt_wrap_pc", pc, 64'h300);
        clear_br();
        step();
        check("c19_pre_pc", pc, 64'h304);

        // negative 19-bit offset
        id_valid    = 1'b1;
        BrTaken     = 1'b1;
        cond_addr19 = 19'h7FFFF;
        id_pc       = 64'h300;
        step();
        check("c19_neg_pc", pc, 64'h2FC);
        check("c19_cnt", {48'h0, redirect_cnt}, 64'h1);

        // asynchronous reset between edges, while in SQUASH with a branch pending
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_pc", pc, 64'h0);
        check("arst_fv", {63'h0, fetch_valid}, 64'h0);
        check("arst_cnt", {48'h0, redirect_cnt}, 64'h0);
        check("arst_align", {63'h0, align_err}, 64'h0);
        check("arst_flush", {63'h0, if_id_flush}, 64'h0);
        clear_br();
        #2;
        reset_n = 1'b1;
        step();
        check("post_rst_pc", pc, 64'h0);
        check("post_rst_fv", {63'h0, fetch_valid}, 64'h1);
        step();
        check("post_rst_pc4", pc, 64'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
